// File: rtl/gerador_seno.sv
// Full-period sine sequencer: walks 36 samples (0..350 deg) over a 0..90 deg LUT,
// folding quadrants by symmetry, and presents each sample on a valid/ready port.
module gerador_seno #(
  parameter int DIV    = 4,
  parameter int N_PASS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  output logic [3:0]  lut_addr,
  input  logic [15:0] lut_seno,
  output logic [16:0] amostra,
  output logic [1:0]  quadrante,
  output logic        fim_periodo,
  output logic        valid,
  input  logic        ready
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [5:0]    N_LAST   = 6'(4 * N_PASS - 1);
  localparam logic [5:0]    N_Q1     = 6'(N_PASS);
  localparam logic [5:0]    N_Q2     = 6'(2 * N_PASS);
  localparam logic [5:0]    N_Q3     = 6'(3 * N_PASS);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] GERANDO = 2'd1;
  localparam logic [1:0] PAUSA   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [5:0]    n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [16:0]   amostra_q, amostra_d;
  logic [1:0]    quadrante_q, quadrante_d;
  logic          fim_periodo_q, fim_periodo_d;

  logic [1:0]    quad_s;
  logic [3:0]    k_s;
  logic [3:0]    addr_s;
  logic [16:0]   mag_s;
  logic [16:0]   samp_s;
  logic          emit_s;
  logic          accept_s;

  // Quadrant/offset decode of n; odd quadrants read the LUT backwards.
  always_comb begin
    quad_s = 2'd0;
    k_s    = 4'd0;
    if (n_q < N_Q1) begin
      quad_s = 2'd0;
      k_s    = n_q[3:0];
    end else if (n_q < N_Q2) begin
      quad_s = 2'd1;
      k_s    = 4'(n_q - N_Q1);
    end else if (n_q < N_Q3) begin
      quad_s = 2'd2;
      k_s    = 4'(n_q - N_Q2);
    end else begin
      quad_s = 2'd3;
      k_s    = 4'(n_q - N_Q3);
    end
    if (quad_s[0]) begin
      addr_s = 4'(N_PASS) - k_s;
    end else begin
      addr_s = k_s;
    end
  end

  // Widen before negating so that -32768 fits without overflow.
  always_comb begin
    mag_s = {1'b0, lut_seno};
    if (quad_s[1]) begin
      samp_s = 17'd0 - mag_s;
    end else begin
      samp_s = mag_s;
    end
  end

  assign emit_s   = (state_q == GERANDO) && (cnt_q == CNT_LAST) && (!valid_q || ready);
  assign accept_s = valid_q && ready;

  // Next-state logic: clear dominates, then FSM, slot counter and output holding register.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    amostra_d     = amostra_q;
    quadrante_d   = quadrante_q;
    fim_periodo_d = fim_periodo_q;
    if (clear) begin
      state_d       = OCIOSO;
      n_d           = 6'd0;
      cnt_d         = '0;
      valid_d       = 1'b0;
      amostra_d     = 17'd0;
      quadrante_d   = 2'd0;
      fim_periodo_d = 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (enable) state_d = GERANDO;
          else        state_d = OCIOSO;
        end
        GERANDO: begin
          if (!enable) state_d = PAUSA;
          else         state_d = GERANDO;
        end
        PAUSA: begin
          if (enable) state_d = GERANDO;
          else        state_d = PAUSA;
        end
        default: state_d = OCIOSO;
      endcase

      if (emit_s) begin
        amostra_d     = samp_s;
        quadrante_d   = quad_s;
        fim_periodo_d = (n_q == N_LAST);
        valid_d       = 1'b1;
        cnt_d         = '0;
        if (n_q == N_LAST) n_d = 6'd0;
        else               n_d = n_q + 6'd1;
      end else begin
        if (accept_s) valid_d = 1'b0;
        else          valid_d = valid_q;
        // At the last slot with a blocked sample the counter simply waits.
        if ((state_q == GERANDO) && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CW'(1);
        else                                             cnt_d = cnt_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OCIOSO;
      n_q           <= 6'd0;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      amostra_q     <= 17'd0;
      quadrante_q   <= 2'd0;
      fim_periodo_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      amostra_q     <= amostra_d;
      quadrante_q   <= quadrante_d;
      fim_periodo_q <= fim_periodo_d;
    end
  end

  assign lut_addr    = addr_s;
  assign amostra     = amostra_q;
  assign quadrante   = quadrante_q;
  assign fim_periodo = fim_periodo_q;
  assign valid       = valid_q;

endmodule
